// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-wide register-file memory, with PSLVERR on out-of-range addresses.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per transfer (default: zero-wait).
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    ready_q, ready_d;
  logic                    slverr_q, slverr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;

  logic                    setup_err, access_err;
  logic [IdxW-1:0]         setup_idx, access_idx;

  assign setup_err  = ({1'b0, PADDR} >= DepthW);
  assign access_err = ({1'b0, addr_q} >= DepthW);
  assign setup_idx  = PADDR[IdxW-1:0];
  assign access_idx = addr_q[IdxW-1:0];

`ifdef APB_SLV_WAIT_EN
  localparam int unsigned   CntW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WAIT_CYCLES);
  localparam bit            ZeroWait = (WAIT_CYCLES == 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam bit ZeroWait = 1'b1;

  logic unused_wait_cycles;
  assign unused_wait_cycles = ^WAIT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    ready_d  = ready_q;
    slverr_d = slverr_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          state_d = StAccess;
          addr_d  = PADDR;
          write_d = PWRITE;
          if (ZeroWait) begin
            ready_d  = 1'b1;
            slverr_d = setup_err;
            if (!PWRITE) rdata_d = setup_err ? '0 : mem_q[setup_idx];
          end else begin
            ready_d = 1'b0;
`ifdef APB_SLV_WAIT_EN
            cnt_d   = CntInit;
`endif
          end
        end
      end
      StAccess: begin
        if (!PSEL) begin
          // Master abandoned the transfer: drop it without touching memory.
          state_d  = StIdle;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
`ifdef APB_SLV_WAIT_EN
          cnt_d    = '0;
`endif
        end else if (PENABLE && ready_q) begin
          mem_we   = write_q && !access_err;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
          state_d  = StIdle;
        end
`ifdef APB_SLV_WAIT_EN
        else if (PENABLE) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            ready_d  = 1'b1;
            slverr_d = access_err;
            if (!write_q) rdata_d = access_err ? '0 : mem_q[access_idx];
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      write_q  <= 1'b0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[access_idx] <= PWDATA;
    end
  end

  assign PRDATA  = rdata_q;
  assign PREADY  = ready_q;
  assign PSLVERR = slverr_q;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (slave) answering the APB master's transfers.
- Byte-wide register-file memory of DEPTH entries.
- Optional fixed wait states; PSLVERR on out-of-range address.
- Sits on the master's PSEL/PENABLE/PWRITE/PADDR/PWDATA bus and returns PRDATA/PREADY/PSLVERR; it is the source of the master's read data and error flag.

Parameters:
- ADDR_WIDTH, 8: width of PADDR at the slave (master's slave-select bit already stripped).
- DATA_WIDTH, 8: width of PWDATA/PRDATA.
- DEPTH, 64: number of implemented locations; valid addresses 0..DEPTH-1.
- WAIT_CYCLES, 2: wait states inserted per transfer. Used only when APB_SLV_WAIT_EN is defined.

Ports:
- PCLK  input  1  clock; all state changes on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  transfer address.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data; registered.
- PREADY  output  1  transfer complete; registered.
- PSLVERR  output  1  transfer error, qualified by PREADY; registered.

Behaviour:
- Reset (PRESETn=0, asynchronous): state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0; all memory locations=0; wait counter=0; latched addr/dir=0.
- FSM states: IDLE, ACCESS.
- IDLE -> ACCESS on an edge with PSEL=1 and PENABLE=0 (setup phase). At that edge:
  - latch PADDR and PWRITE;
  - err = (PADDR >= DEPTH).
  - If the wait count is 0: PREADY<=1, PSLVERR<=err, PRDATA<=(read && !err) ? mem[PADDR] : 0.
  - Otherwise: counter<=WAIT_CYCLES, PREADY<=0.
- ACCESS with PSEL=1, PENABLE=1, PREADY=0: counter decrements each edge. At the edge where counter==1: PREADY<=1, PSLVERR<=err, PRDATA<=read data from the latched address.
- ACCESS with PSEL=1, PENABLE=1, PREADY=1 (completion edge):
  - if write and !err: mem[latched addr]<=PWDATA sampled at this edge;
  - PREADY<=0, PSLVERR<=0, state->IDLE;
  - PRDATA holds its value until the next read completes.
- Latency, setup to completion: 2 cycles for zero wait, 2+WAIT_CYCLES cycles otherwise.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted normally. There are no idle cycles between transfers.
- PADDR/PWRITE changes during ACCESS are ignored (latched values are used). PWDATA is sampled only at the completion edge.
- PSEL=0 while in ACCESS (protocol abort): return to IDLE, PREADY<=0, PSLVERR<=0, no memory write.
- PENABLE=1 while in IDLE: ignored; no state change.
- Error transfers (addr >= DEPTH): PSLVERR=1 exactly in the PREADY cycle; write suppressed; PRDATA=0 for reads.
- PSLVERR is never 1 while PREADY=0.
- Addresses wrap only by width: PADDR is compared against DEPTH, never truncated.
- Reset asserted mid-transfer: all outputs clear immediately; memory clears; any in-flight write is discarded.

Optional Feature:
- Macro: APB_SLV_WAIT_EN.
- Defined: WAIT_CYCLES wait states are inserted on every transfer via the down-counter. WAIT_CYCLES=0 is legal and equals zero-wait.
- Undefined: counter logic is not compiled; every transfer completes with PREADY=1 in the first ACCESS cycle, regardless of WAIT_CYCLES.

Test Plan:
- Reset then read addr 0x05 -> PREADY=1 in the first ACCESS cycle (macro off), PRDATA=0x00, PSLVERR=0.
- Write 0xA5 to 0x10, then read 0x10 back-to-back with no idle -> second transfer returns PRDATA=0xA5, PSLVERR=0.
- Macro on, WAIT_CYCLES=2: write 0x3C to 0x3F -> PREADY low for 2 ACCESS cycles, high on the 3rd; a read of 0x3F returns 0x3C.
- Write 0x77 to 0x40 (DEPTH=64) -> PSLVERR=1 with PREADY; a subsequent read of 0x40 gives PSLVERR=1, PRDATA=0x00; locations 0x00..0x3F are unchanged.
- Macro on, write 0x11 to 0x08, drop PSEL after 1 wait cycle -> FSM returns to IDLE, PREADY stays 0; a read of 0x08 returns 0x00.
- Write 0xFF to 0x02, assert PRESETn=0 mid-ACCESS -> PREADY/PSLVERR/PRDATA go 0 immediately; after release, a read of 0x02 returns 0x00.
